// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: a single outstanding word read over req/ack.
// Valid/ready contract: once imem_req rises, imem_req and imem_addr hold until the cycle imem_ack=1,
// and imem_rdata is sampled only in that ack cycle. Reset may drop imem_req at any time.
interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, streams word reads from instruction memory and presents
// one instruction per cycle to decode, with a one-entry skid for stalls and redirect flushing.
module instruction_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                OPCODE_LSB = 13
) (
  input  logic                   clock,
  input  logic                   reset,
  instruction_fetch_if.master    imem,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   stall,
  output logic                   if_valid,
  output logic [DATA_W-1:0]      if_instr,
  output logic [ADDR_W-1:0]      if_pc,
  output logic [ADDR_W-1:0]      if_pc_next,
  output logic [2:0]             opcode,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] if_pc_next_q, if_pc_next_d;
  logic [2:0]        opcode_q, opcode_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic              load_en;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] load_pc;
  logic              out_free;

  assign out_free = !valid_q || !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    if_pc_d      = if_pc_q;
    if_pc_next_d = if_pc_next_q;
    opcode_d     = opcode_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    load_en      = 1'b0;
    load_data    = imem.imem_rdata;
    load_pc      = pc_q;

    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_q;
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (out_free) begin
            load_en = 1'b1;
          end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
          pc_d   = pc_q + ADDR_W'(1);
          addr_d = pc_q + ADDR_W'(1);
        end
      end
      HOLD: begin
        if (!stall) begin
          load_en      = skid_valid_q;
          load_data    = skid_data_q;
          load_pc      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = REQ;
          addr_d       = pc_q;
        end
      end
      DROP: begin
        if (imem.imem_ack) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_en) begin
      valid_d      = 1'b1;
      instr_d      = load_data;
      if_pc_d      = load_pc;
      if_pc_next_d = load_pc + ADDR_W'(1);
      opcode_d     = load_data[OPCODE_LSB+2:OPCODE_LSB];
    end

    // A redirect outranks ack and stall; a wrong-path request still on the bus must drain in DROP.
    if (redirect) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc;
      case (state_q)
        REQ: begin
          if (imem.imem_ack) begin
            state_d = REQ;
            addr_d  = redirect_pc;
          end else begin
            state_d = DROP;
            addr_d  = addr_q;
          end
        end
        DROP: begin
          state_d = DROP;
          addr_d  = addr_q;
        end
        default: begin
          state_d = REQ;
          addr_d  = redirect_pc;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      if_pc_q      <= '0;
      if_pc_next_q <= '0;
      opcode_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      if_pc_q      <= if_pc_d;
      if_pc_next_q <= if_pc_next_d;
      opcode_q     <= opcode_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr = addr_q;
  assign if_valid       = valid_q;
  assign if_instr       = instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_next     = if_pc_next_q;
  assign opcode         = opcode_q;
  assign state_dbg      = state_q;

endmodule
